// File: rtl/filter_sequencer.sv
// Sample-rate sequencer for a first-order IIR datapath: sample tick, ADC handshake, settle wait,
// result capture and coefficient shadow registers that switch over only between samples.
module filter_sequencer #(
    parameter int               DW      = 32,
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = 16'd99,
    parameter int               SETTLE  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we_i,
    input  logic [1:0]    cfg_addr_i,
    input  logic [DW-1:0] cfg_wdata_i,
    input  logic          cfg_commit_i,
    input  logic          ovr_clr_i,
    input  logic          adc_valid_i,
    input  logic [DW-1:0] adc_data_i,
    output logic          adc_ready_o,
    output logic [DW-1:0] filt_data_in_o,
    output logic [DW-1:0] filt_a1_o,
    output logic [DW-1:0] filt_b0_o,
    output logic [DW-1:0] filt_b1_o,
    output logic          filt_en_o,
    input  logic [DW-1:0] filt_yn_i,
    output logic          y_valid_o,
    output logic [DW-1:0] y_data_o,
    output logic          busy_o,
    output logic          overrun_o
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SMP, ST_SETTLE, ST_OUTPUT} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [DIV_W-1:0] cnt_q, div_q, div_sh_q;
    logic             tick;
    logic             handshake;
    logic             commit_now;
    logic             commit_pend_q;
    logic [DW-1:0]    sh_q  [3];
    logic [DW-1:0]    act_q [3];
    logic [DW-1:0]    x_q, y_q;
    logic             y_valid_q, overrun_q;

    assign tick       = (cnt_q == div_q);
    assign handshake  = adc_valid_i & adc_ready_o;
    assign commit_now = (state_q == ST_IDLE) & commit_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_WAIT_SMP;
            end
            ST_WAIT_SMP: begin
                if (adc_valid_i) begin
                    state_d  = ST_SETTLE;
                    settle_d = SW'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_OUTPUT;
                else                settle_d = settle_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        adc_ready_o = 1'b0;
        filt_en_o   = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            ST_IDLE:     busy_o      = 1'b0;
            ST_WAIT_SMP: adc_ready_o = 1'b1;
            ST_OUTPUT:   filt_en_o   = 1'b1;
            default:     busy_o      = 1'b1;
        endcase
    end

    // A new divisor is only picked up on a wrap, so the running period always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= DIV_RST;
            div_sh_q <= DIV_RST;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) div_q <= div_sh_q;
            if (cfg_we_i && cfg_addr_i == 2'd3) div_sh_q <= cfg_wdata_i[DIV_W-1:0];
        end
    end

    // Copy reads the shadow before any same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sh_q[i]  <= '0;
                act_q[i] <= '0;
            end
            commit_pend_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cfg_we_i && cfg_addr_i == 2'(i)) sh_q[i] <= cfg_wdata_i;
                if (commit_now) act_q[i] <= sh_q[i];
            end
            commit_pend_q <= cfg_commit_i | (commit_pend_q & ~commit_now);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (handshake) x_q <= adc_data_i;
            if (state_q == ST_OUTPUT) y_q <= filt_yn_i;
            y_valid_q <= (state_q == ST_OUTPUT);
            if (tick && state_q != ST_IDLE) overrun_q <= 1'b1;
            else if (ovr_clr_i)             overrun_q <= 1'b0;
        end
    end

    assign filt_data_in_o = x_q;
    assign filt_a1_o      = act_q[0];
    assign filt_b0_o      = act_q[1];
    assign filt_b1_o      = act_q[2];
    assign y_data_o       = y_q;
    assign y_valid_o      = y_valid_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: random stimulus against a sample-level reference model and a
// simple stand-in filter whose output depends on the held sample, coefficients and w[n-1].
module tb_filter_sequencer;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_commit = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        adc_valid = 1'b0;
    logic [31:0] adc_data = '0;
    logic        adc_ready, filt_en, y_valid, busy, overrun;
    logic [31:0] filt_data_in, filt_a1, filt_b0, filt_b1, filt_yn, y_data;
    logic [31:0] w_q;

    int npass = 0;
    int nchk  = 0;

    // Reference model state
    int          m_cnt, m_div, m_div_sh, m_left;
    bit          m_wait, m_pend, m_ovr, m_yv;
    logic [31:0] m_x, m_y, m_w;
    logic [31:0] m_sh  [3];
    logic [31:0] m_act [3];
    bit          e_busy, e_ready, e_en;

    always #5 clk = ~clk;

    filter_sequencer #(.DW(32), .DIV_W(16), .DIV_RST(16'd99), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_commit_i(cfg_commit), .ovr_clr_i(ovr_clr),
        .adc_valid_i(adc_valid), .adc_data_i(adc_data), .adc_ready_o(adc_ready),
        .filt_data_in_o(filt_data_in), .filt_a1_o(filt_a1), .filt_b0_o(filt_b0),
        .filt_b1_o(filt_b1), .filt_en_o(filt_en), .filt_yn_i(filt_yn),
        .y_valid_o(y_valid), .y_data_o(y_data), .busy_o(busy), .overrun_o(overrun)
    );

    // Stand-in filter datapath with its own w[n-1] register
    assign filt_yn = filt_data_in + filt_b0 + (filt_a1 << 1) + (filt_b1 << 3) + w_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       w_q <= '0;
        else if (filt_en) w_q <= filt_data_in;
    end

    task automatic m_reset();
        m_cnt = 0; m_div = 99; m_div_sh = 99; m_left = 0;
        m_wait = 0; m_pend = 0; m_ovr = 0; m_yv = 0;
        m_x = '0; m_y = '0; m_w = '0;
        for (int i = 0; i < 3; i++) begin m_sh[i] = '0; m_act[i] = '0; end
        e_busy = 0; e_ready = 0; e_en = 0;
    endtask

    task automatic clr();
        cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 0;
        ovr_clr = 0; adc_valid = 0; adc_data = '0;
    endtask

    // Advance one clock: model follows the edge, then return on the falling edge.
    task automatic step();
        bit tick, idle, copy;
        int old_div_sh;
        @(posedge clk);
        tick = (m_cnt == m_div);
        idle = !m_wait && m_left == 0;
        old_div_sh = m_div_sh;
        m_yv = (m_left == 1);
        if (m_yv) begin
            m_y = m_x + m_act[1] + (m_act[0] << 1) + (m_act[2] << 3) + m_w;
            m_w = m_x;
        end
        copy = idle && m_pend;
        if (copy) m_act = m_sh;
        m_pend = cfg_commit || (m_pend && !copy);
        if (cfg_we) begin
            if (cfg_addr == 2'd3) m_div_sh = int'(cfg_wdata[15:0]);
            else                  m_sh[cfg_addr] = cfg_wdata;
        end
        if (tick && !idle) m_ovr = 1;
        else if (ovr_clr)  m_ovr = 0;
        if (m_left > 0) m_left--;
        else if (m_wait && adc_valid) begin m_wait = 0; m_left = SETTLE + 1; m_x = adc_data; end
        else if (idle && tick) m_wait = 1;
        if (tick) begin m_cnt = 0; m_div = old_div_sh; end
        else m_cnt++;
        e_busy = m_wait || m_left > 0; e_ready = m_wait; e_en = (m_left == 1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        nchk++; if ({busy, adc_ready, y_valid, filt_en, overrun} !== 5'b0) $display("FAIL reset_flags got=%b exp=00000", {busy, adc_ready, y_valid, filt_en, overrun}); else npass++;
        nchk++; if (y_data !== 32'h0) $display("FAIL reset_y_data got=%h exp=0", y_data); else npass++;
        nchk++; if ({filt_a1, filt_b0, filt_b1} !== 96'h0) $display("FAIL reset_coef got=%h exp=0", {filt_a1, filt_b0, filt_b1}); else npass++;
        nchk++; if (filt_data_in !== 32'h0) $display("FAIL reset_data_in got=%h exp=0", filt_data_in); else npass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        m_reset();
        step();
        nchk++; if (busy !== 1'b0) $display("FAIL reset_release_busy got=%b exp=0", busy); else npass++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 160; i++) begin
            clr(); adc_valid = 1; adc_data = $urandom;
            if (i < 3) begin cfg_we = 1; cfg_addr = 2'(i); cfg_wdata = $urandom; end
            else if (i == 3) begin cfg_we = 1; cfg_addr = 2'd3; cfg_wdata = 32'd4; end
            else if (i == 4) cfg_commit = 1;
            step();
            nchk++; if (busy !== e_busy) $display("FAIL basic_busy cyc=%0d got=%b exp=%b", i, busy, e_busy); else npass++;
            nchk++; if (adc_ready !== e_ready) $display("FAIL basic_ready cyc=%0d got=%b exp=%b", i, adc_ready, e_ready); else npass++;
            nchk++; if (y_valid !== m_yv) $display("FAIL basic_y_valid cyc=%0d got=%b exp=%b", i, y_valid, m_yv); else npass++;
            nchk++; if (y_data !== m_y) $display("FAIL basic_y_data cyc=%0d got=%h exp=%h", i, y_data, m_y); else npass++;
            nchk++; if (overrun !== m_ovr) $display("FAIL basic_overrun cyc=%0d got=%b exp=%b", i, overrun, m_ovr); else npass++;
            nchk++; if (filt_b0 !== m_act[1]) $display("FAIL basic_b0 cyc=%0d got=%h exp=%h", i, filt_b0, m_act[1]); else npass++;
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 60; i++) begin
            clr(); adc_valid = 1; adc_data = $urandom;
            ovr_clr = ($urandom_range(0, 3) == 0);
            if (i == 0) begin cfg_we = 1; cfg_addr = 2'd3; cfg_wdata = 32'd1; end
            step();
            nchk++; if (overrun !== m_ovr) $display("FAIL ovr_overrun cyc=%0d got=%b exp=%b", i, overrun, m_ovr); else npass++;
            nchk++; if (y_valid !== m_yv) $display("FAIL ovr_y_valid cyc=%0d got=%b exp=%b", i, y_valid, m_yv); else npass++;
            nchk++; if (y_data !== m_y) $display("FAIL ovr_y_data cyc=%0d got=%h exp=%h", i, y_data, m_y); else npass++;
            nchk++; if (busy !== e_busy) $display("FAIL ovr_busy cyc=%0d got=%b exp=%b", i, busy, e_busy); else npass++;
        end
    endtask

    task automatic test_commit_mid();
        int phase = 0;
        for (int i = 0; i < 80; i++) begin
            clr(); adc_valid = 1; adc_data = $urandom;
            if (i == 0) begin cfg_we = 1; cfg_addr = 2'd3; cfg_wdata = 32'd7; end
            else if (phase == 0 && m_left == SETTLE + 1) begin
                cfg_we = 1; cfg_addr = 2'd1; cfg_wdata = $urandom; phase = 1;
            end else if (phase == 1) begin cfg_commit = 1; phase = 2; end
            step();
            nchk++; if (filt_b0 !== m_act[1]) $display("FAIL commit_b0 cyc=%0d got=%h exp=%h", i, filt_b0, m_act[1]); else npass++;
            nchk++; if (y_valid !== m_yv) $display("FAIL commit_y_valid cyc=%0d got=%b exp=%b", i, y_valid, m_yv); else npass++;
            nchk++; if (y_data !== m_y) $display("FAIL commit_y_data cyc=%0d got=%h exp=%h", i, y_data, m_y); else npass++;
        end
        nchk++; if (phase !== 2) $display("FAIL commit_reached_settle got=%0d exp=2", phase); else npass++;
    endtask

    task automatic test_stall();
        int stall = 0;
        for (int i = 0; i < 130; i++) begin
            clr(); adc_data = $urandom;
            if (i == 0) begin cfg_we = 1; cfg_addr = 2'd3; cfg_wdata = 32'd9; end
            if (m_wait && stall < 50) stall++;
            else adc_valid = 1;
            step();
            nchk++; if (adc_ready !== e_ready) $display("FAIL stall_ready cyc=%0d got=%b exp=%b", i, adc_ready, e_ready); else npass++;
            nchk++; if (busy !== e_busy) $display("FAIL stall_busy cyc=%0d got=%b exp=%b", i, busy, e_busy); else npass++;
            nchk++; if (overrun !== m_ovr) $display("FAIL stall_overrun cyc=%0d got=%b exp=%b", i, overrun, m_ovr); else npass++;
            nchk++; if (y_data !== m_y) $display("FAIL stall_y_data cyc=%0d got=%h exp=%h", i, y_data, m_y); else npass++;
        end
        nchk++; if (stall !== 50) $display("FAIL stall_length got=%0d exp=50", stall); else npass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr();
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_wdata = (cfg_addr == 2'd3) ? 32'($urandom_range(0, 6)) : 32'($urandom);
            cfg_commit = ($urandom_range(0, 9) == 0);
            ovr_clr = ($urandom_range(0, 7) == 0);
            adc_valid = $urandom_range(0, 1);
            adc_data = $urandom;
            step();
            nchk++; if ({busy, adc_ready, filt_en} !== {e_busy, e_ready, e_en}) $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", i, {busy, adc_ready, filt_en}, {e_busy, e_ready, e_en}); else npass++;
            nchk++; if ({y_valid, overrun} !== {m_yv, m_ovr}) $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {y_valid, overrun}, {m_yv, m_ovr}); else npass++;
            nchk++; if (y_data !== m_y) $display("FAIL rnd_y_data cyc=%0d got=%h exp=%h", i, y_data, m_y); else npass++;
            nchk++; if (filt_data_in !== m_x) $display("FAIL rnd_data_in cyc=%0d got=%h exp=%h", i, filt_data_in, m_x); else npass++;
            nchk++; if ({filt_a1, filt_b0, filt_b1} !== {m_act[0], m_act[1], m_act[2]}) $display("FAIL rnd_coef cyc=%0d got=%h exp=%h", i, {filt_a1, filt_b0, filt_b1}, {m_act[0], m_act[1], m_act[2]}); else npass++;
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 0;
        int first = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            clr(); adc_valid = 1; adc_data = $urandom | 32'h1;
            if (i == 0) begin cfg_we = 1; cfg_addr = 2'd3; cfg_wdata = 32'd5; end
            step();
            reached = (m_left == SETTLE);
        end
        nchk++; if (!reached) $display("FAIL rstmid_reach_settle got=0 exp=1"); else npass++;
        rst_n = 0;
        #1;
        nchk++; if ({busy, adc_ready, y_valid, filt_en, overrun} !== 5'b0) $display("FAIL rstmid_flags got=%b exp=00000", {busy, adc_ready, y_valid, filt_en, overrun}); else npass++;
        nchk++; if ({y_data, filt_data_in, filt_a1, filt_b0, filt_b1} !== 160'h0) $display("FAIL rstmid_data got=%h exp=0", {y_data, filt_data_in, filt_a1, filt_b0, filt_b1}); else npass++;
        m_reset();
        clr();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nchk++; if (y_valid !== 1'b0) $display("FAIL rstmid_no_y_valid cyc=%0d got=%b exp=0", i, y_valid); else npass++;
        end
        rst_n = 1;
        for (int n = 1; n <= 110; n++) begin
            clr(); adc_valid = 1; adc_data = $urandom;
            step();
            if (busy && first == 0) first = n;
            nchk++; if (busy !== e_busy) $display("FAIL rstmid_busy cyc=%0d got=%b exp=%b", n, busy, e_busy); else npass++;
        end
        nchk++; if (first !== 100) $display("FAIL rstmid_first_tick got=%0d exp=100", first); else npass++;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_commit_mid();
        test_stall();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
